// File: rtl/mem_controller_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// State encodings are fixed so external monitors can decode the debug state.
package mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELAY      = 2'd3
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_controller_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr_i is always < N, so one conditional subtract is enough to wrap.
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o           = 1'b1;
        grant_idx_o     = idx[IDX_W-1:0];
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Round-robin arbiter sharing one external data-memory port among several LSUs.
// Valid/ready: consumers hold valid as a level; ready is held until the granted valid drops.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output state_e                           dbg_state_o
);

  localparam int N     = NUM_CONSUMERS;
  localparam int IDX_W = idx_width(NUM_CONSUMERS);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   mrv_q, mrv_d;
  logic [ADDR_BITS-1:0]   mra_q, mra_d;
  logic                   mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]   mwa_q, mwa_d;
  logic [DATA_BITS-1:0]   mwd_q, mwd_d;
  logic [N-1:0]           rrdy_q, rrdy_d;
  logic [N-1:0]           wrdy_q, wrdy_d;
  logic [N*DATA_BITS-1:0] rdata_q, rdata_d;

  logic [N-1:0]     arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req_i       (consumer_read_valid | consumer_write_valid),
    .ptr_i       (ptr_q),
    .grant_oh_o  (arb_oh),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    mrv_d   = mrv_q;
    mra_d   = mra_q;
    mwv_d   = mwv_q;
    mwa_d   = mwa_q;
    mwd_d   = mwd_q;
    rrdy_d  = rrdy_q;
    wrdy_d  = wrdy_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          // Read has priority over write on the same LSU.
          if (consumer_read_valid[arb_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = consumer_read_address[arb_idx*ADDR_BITS +: ADDR_BITS];
            state_d = ST_READ_WAIT;
          end else begin
            mwv_d   = 1'b1;
            mwa_d   = consumer_write_address[arb_idx*ADDR_BITS +: ADDR_BITS];
            mwd_d   = consumer_write_data[arb_idx*DATA_BITS +: DATA_BITS];
            state_d = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (mem_read_ready) begin
          mrv_d                                   = 1'b0;
          rdata_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          rrdy_d[grant_q]                         = 1'b1;
          state_d                                 = ST_RELAY;
        end
      end
      ST_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mwv_d           = 1'b0;
          wrdy_d[grant_q] = 1'b1;
          state_d         = ST_RELAY;
        end
      end
      ST_RELAY: begin
        if ((rrdy_q[grant_q] && !consumer_read_valid[grant_q]) ||
            (wrdy_q[grant_q] && !consumer_write_valid[grant_q])) begin
          rrdy_d  = '0;
          wrdy_d  = '0;
          ptr_d   = (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      mrv_q   <= 1'b0;
      mra_q   <= '0;
      mwv_q   <= 1'b0;
      mwa_q   <= '0;
      mwd_q   <= '0;
      rrdy_q  <= '0;
      wrdy_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      mrv_q   <= mrv_d;
      mra_q   <= mra_d;
      mwv_q   <= mwv_d;
      mwa_q   <= mwa_d;
      mwd_q   <= mwd_d;
      rrdy_q  <= rrdy_d;
      wrdy_q  <= wrdy_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;
  assign consumer_read_ready  = rrdy_q;
  assign consumer_write_ready = wrdy_q;
  assign consumer_read_data   = rdata_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: reset, single read/write, round-robin order,
// read-over-write priority, reset abort, held valid and valid dropped mid-transaction.
module tb_mem_controller;
  import mem_controller_pkg::*;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] consumer_read_valid;
  logic [N*A-1:0] consumer_read_address;
  logic [N-1:0] consumer_read_ready;
  logic [N*D-1:0] consumer_read_data;
  logic [N-1:0] consumer_write_valid;
  logic [N*A-1:0] consumer_write_address;
  logic [N*D-1:0] consumer_write_data;
  logic [N-1:0] consumer_write_ready;
  logic         mem_read_valid;
  logic [A-1:0] mem_read_address;
  logic         mem_read_ready;
  logic [D-1:0] mem_read_data;
  logic         mem_write_valid;
  logic [A-1:0] mem_write_address;
  logic [D-1:0] mem_write_data;
  logic         mem_write_ready;
  state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .dbg_state_o            (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset                  = 1'b1;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    mem_read_ready         = 1'b0;
    mem_read_data          = '0;
    mem_write_ready        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_mem_read(input logic [D-1:0] data);
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
  endtask

  task automatic pulse_mem_write();
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
      errors++;
      $display("FAIL reset_mem_outs: got rv=%b wv=%b ra=%h wa=%h wd=%h, want all 0",
               mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data);
    end
    checks++;
    if ({consumer_read_ready, consumer_write_ready, consumer_read_data} !== '0) begin
      errors++;
      $display("FAIL reset_consumer_outs: got rr=%b wr=%b rd=%h, want all 0",
               consumer_read_ready, consumer_write_ready, consumer_read_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want 0", dbg_state);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    consumer_read_valid[2]       = 1'b1;
    consumer_read_address[2*A +: A] = 8'h10;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10 || mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: got rv=%b ra=%h wv=%b, want 1/10/0",
               mem_read_valid, mem_read_address, mem_write_valid);
    end
    consumer_read_address[2*A +: A] = 8'h77;
    tick();
    tick();
    checks++;
    if (mem_read_address !== 8'h10 || consumer_read_ready !== 4'b0000) begin
      errors++;
      $display("FAIL read_hold: got ra=%h rr=%b, want 10/0000", mem_read_address, consumer_read_ready);
    end
    pulse_mem_read(8'hAB);
    checks++;
    if (consumer_read_ready !== 4'b0100 || consumer_read_data[2*D +: D] !== 8'hAB || mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_ready: got rr=%b rd2=%h rv=%b, want 0100/ab/0",
               consumer_read_ready, consumer_read_data[2*D +: D], mem_read_valid);
    end
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0100) begin
      errors++;
      $display("FAIL read_ready_hold: got %b, want 0100", consumer_read_ready);
    end
    consumer_read_valid[2] = 1'b0;
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL read_release: got rr=%b st=%0d, want 0000/0", consumer_read_ready, dbg_state);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    consumer_write_valid[0]         = 1'b1;
    consumer_write_address[0 +: A]  = 8'h22;
    consumer_write_data[0 +: D]     = 8'h5C;
    tick();
    checks++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h22 || mem_write_data !== 8'h5C ||
        mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_issue: got wv=%b wa=%h wd=%h rv=%b, want 1/22/5c/0",
               mem_write_valid, mem_write_address, mem_write_data, mem_read_valid);
    end
    pulse_mem_write();
    checks++;
    if (consumer_write_ready !== 4'b0001 || mem_write_valid !== 1'b0 || mem_read_valid !== 1'b0 ||
        consumer_read_ready !== 4'b0000) begin
      errors++;
      $display("FAIL write_ack: got wr=%b wv=%b rv=%b rr=%b, want 0001/0/0/0000",
               consumer_write_ready, mem_write_valid, mem_read_valid, consumer_read_ready);
    end
    consumer_write_valid[0] = 1'b0;
    tick();
    checks++;
    if (consumer_write_ready !== 4'b0000) begin
      errors++;
      $display("FAIL write_release: got %b, want 0000", consumer_write_ready);
    end
  endtask

  task automatic test_round_robin();
    int order_a[4];
    int order_b[2];
    order_a = '{0, 1, 2, 3};
    order_b = '{0, 3};
    do_reset();
    for (int i = 0; i < N; i++) consumer_read_address[i*A +: A] = 8'(8'h40 + i);
    consumer_read_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      int e;
      logic [D-1:0] rdat;
      if (j == 4) begin
        consumer_read_valid = 4'b1001;
      end
      e    = (j < 4) ? order_a[j] : order_b[j-4];
      rdat = 8'(8'hC0 + e);
      for (int k = 0; k < 10 && mem_read_valid !== 1'b1; k++) tick();
      checks++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'(8'h40 + e)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got rv=%b ra=%h, want 1/%h", j, mem_read_valid,
                 mem_read_address, 8'(8'h40 + e));
      end
      pulse_mem_read(rdat);
      checks++;
      if (consumer_read_ready !== 4'(1 << e) || consumer_read_data[e*D +: D] !== rdat) begin
        errors++;
        $display("FAIL rr_ready_%0d: got rr=%b rd=%h, want %b/%h", j, consumer_read_ready,
                 consumer_read_data[e*D +: D], 4'(1 << e), rdat);
      end
      consumer_read_valid[e] = 1'b0;
      tick();
    end
  endtask

  task automatic test_read_write_same();
    do_reset();
    consumer_read_valid[1]           = 1'b1;
    consumer_write_valid[1]          = 1'b1;
    consumer_read_address[1*A +: A]  = 8'h31;
    consumer_write_address[1*A +: A] = 8'h32;
    consumer_write_data[1*D +: D]    = 8'h99;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h31) begin
      errors++;
      $display("FAIL rw_read_first: got rv=%b wv=%b ra=%h, want 1/0/31",
               mem_read_valid, mem_write_valid, mem_read_address);
    end
    pulse_mem_read(8'h11);
    checks++;
    if (consumer_read_ready !== 4'b0010 || consumer_write_ready !== 4'b0000 ||
        consumer_read_data[1*D +: D] !== 8'h11) begin
      errors++;
      $display("FAIL rw_read_ack: got rr=%b wr=%b rd1=%h, want 0010/0000/11",
               consumer_read_ready, consumer_write_ready, consumer_read_data[1*D +: D]);
    end
    consumer_read_valid[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_write_valid !== 1'b1 || mem_read_valid !== 1'b0 || mem_write_address !== 8'h32 ||
        mem_write_data !== 8'h99) begin
      errors++;
      $display("FAIL rw_write_later: got wv=%b rv=%b wa=%h wd=%h, want 1/0/32/99",
               mem_write_valid, mem_read_valid, mem_write_address, mem_write_data);
    end
    pulse_mem_write();
    checks++;
    if (consumer_write_ready !== 4'b0010 || consumer_read_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rw_write_ack: got wr=%b rr=%b, want 0010/0000", consumer_write_ready, consumer_read_ready);
    end
    consumer_write_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    consumer_read_valid[1]          = 1'b1;
    consumer_read_address[1*A +: A] = 8'h05;
    tick();
    checks++;
    if (dbg_state !== ST_READ_WAIT || mem_read_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got st=%0d rv=%b, want 1/1", dbg_state, mem_read_valid);
    end
    consumer_read_valid[1]          = 1'b0;
    consumer_read_valid[3]          = 1'b1;
    consumer_read_address[3*A +: A] = 8'h3C;
    reset                           = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
        consumer_read_ready !== 4'b0000 || mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got st=%0d rv=%b ra=%h rr=%b wv=%b, want 0/0/00/0000/0",
               dbg_state, mem_read_valid, mem_read_address, consumer_read_ready, mem_write_valid);
    end
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h3C) begin
      errors++;
      $display("FAIL mid_regrant: got rv=%b ra=%h, want 1/3c", mem_read_valid, mem_read_address);
    end
    pulse_mem_read(8'h77);
    checks++;
    if (consumer_read_ready !== 4'b1000 || consumer_read_data[3*D +: D] !== 8'h77) begin
      errors++;
      $display("FAIL mid_ready: got rr=%b rd3=%h, want 1000/77", consumer_read_ready,
               consumer_read_data[3*D +: D]);
    end
    consumer_read_valid[3] = 1'b0;
    tick();
  endtask

  task automatic test_held_valid();
    do_reset();
    consumer_read_valid[0]          = 1'b1;
    consumer_read_address[0 +: A]   = 8'h50;
    consumer_read_address[1*A +: A] = 8'h51;
    tick();
    pulse_mem_read(8'h5A);
    consumer_read_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (consumer_read_ready !== 4'b0001 || mem_read_valid !== 1'b0 || dbg_state !== ST_RELAY) begin
        errors++;
        $display("FAIL held_cycle_%0d: got rr=%b rv=%b st=%0d, want 0001/0/3", c,
                 consumer_read_ready, mem_read_valid, dbg_state);
      end
    end
    consumer_read_valid[0] = 1'b0;
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL held_release: got rr=%b st=%0d, want 0000/0", consumer_read_ready, dbg_state);
    end
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h51) begin
      errors++;
      $display("FAIL held_next_grant: got rv=%b ra=%h, want 1/51", mem_read_valid, mem_read_address);
    end
  endtask

  task automatic test_drop_during_wait();
    do_reset();
    consumer_write_valid[2]          = 1'b1;
    consumer_write_address[2*A +: A] = 8'h12;
    consumer_write_data[2*D +: D]    = 8'h34;
    tick();
    consumer_write_valid[2] = 1'b0;
    tick();
    checks++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h12 || mem_write_data !== 8'h34) begin
      errors++;
      $display("FAIL drop_still_issued: got wv=%b wa=%h wd=%h, want 1/12/34",
               mem_write_valid, mem_write_address, mem_write_data);
    end
    pulse_mem_write();
    checks++;
    if (consumer_write_ready !== 4'b0100 || dbg_state !== ST_RELAY) begin
      errors++;
      $display("FAIL drop_pulse: got wr=%b st=%0d, want 0100/3", consumer_write_ready, dbg_state);
    end
    tick();
    checks++;
    if (consumer_write_ready !== 4'b0000 || dbg_state !== ST_IDLE || mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_return: got wr=%b st=%0d wv=%b, want 0000/0/0",
               consumer_write_ready, dbg_state, mem_write_valid);
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_read_write_same();
    test_reset_mid();
    test_held_valid();
    test_drop_during_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
